id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//  Registered RV32I instruction-decode pipeline stage placed between the IF and EX stages.
//  It decodes the instruction, reads the register file and builds both ALU operands.
//  Pipeline control: valid/ready handshake, load-use stall insertion, flush, sticky HALT.
//  Replaces the purely combinational decoder for the pipelined core.
// PARAMETERS
//  PC_W        32            width of PC fields
//  HALT_INST   32'h00008067  instruction encoding that can halt the core (JALR x0,0(x1))
//  HALT_RD1    32'h0000000c  rs1 value that, together with HALT_INST, halts the core
//  LU_STALL    1             1: detect and stall load-use hazards; 0: never stall (hazards handled elsewhere)
// PORTS
//  CLK          in   1     clock, rising edge
//  RSTn         in   1     asynchronous reset, active low
//  in_valid     in   1     IF has an instruction
//  in_ready     out  1     stage accepts the instruction this cycle
//  in_inst      in   32    instruction word
//  in_pc        in   PC_W  instruction PC
//  flush        in   1     kill the instruction in this stage and the one offered by IF
//  ex_valid     in   1     EX stage holds a valid instruction
//  ex_is_load   in   1     the EX instruction is a load
//  ex_rd        in   5     destination register of the EX instruction
//  RF_RA1       out  5     read address 1 = in_inst[19:15] (combinational)
//  RF_RA2       out  5     read address 2 = in_inst[24:20] (combinational)
//  RF_RD1       in   32    read data 1
//  RF_RD2       in   32    read data 2
//  out_valid    out  1     ID/EX bundle is valid
//  out_ready    in   1     EX consumes the bundle
//  out_pc       out  PC_W  registered PC
//  out_rd       out  5     destination register (0 when RF_WE=0)
//  out_funct3   out  3     funct3
//  out_funct7   out  7     funct7
//  out_op1      out  32    ALU operand 1
//  out_op2      out  32    ALU operand 2
//  out_rs2_data out  32    rs2 value, used as store data
//  out_imm      out  32    sign-extended immediate for the decoded format
//  out_ctrl     out  11    [0]OPIMM [1]OP [2]JAL [3]JALR [4]BRANCH [5]LOAD [6]STORE [7]LUI [8]AUIPC [9]RF_WE [10]ILLEGAL
//  HALT         out  1     sticky halt indication
// BEHAVIOUR
//  Reset (RSTn low, asynchronous): all registered outputs 0, out_valid=0, HALT=0; in_ready=0 while RSTn is low.
//  Handshakes
//  - accept = in_valid & in_ready.
//  - in_ready = !HALT & !flush & !stall & (!out_valid | out_ready).
//  - Edge with accept: bundle loads and out_valid=1; latency 1 cycle.
//  - Edge with out_ready & !accept: out_valid=0.
//  - Otherwise the bundle holds stable; all out_* are stable while out_valid & !out_ready.
//  Load-use stall (LU_STALL=1)
//  - stall = ex_valid & ex_is_load & ex_rd!=0 & ((use1 & ex_rd==rs1) | (use2 & ex_rd==rs2)).
//  - use1 = not LUI/AUIPC/JAL.
//  - use2 = OP/BRANCH/STORE.
//  - A stalled slot is a bubble, never a duplicate.
//  - LU_STALL=0: stall is tied to 0.
//  Flush: highest priority. Next edge out_valid=0 and in_inst is not captured; HALT is not evaluated.
//  Immediates
//  - I/S/B/J formats: sign-extended from inst[31].
//  - U format: {inst[31:12],12'b0}.
//  - out_imm selects by opcode: LOAD/OPIMM/JALR use I; STORE uses S; BRANCH uses B; LUI/AUIPC use U; JAL uses J.
//  Operands
//  - Register index 0 reads as 0 regardless of RF_RD*.
//  - op1: pc (AUIPC, JAL), 0 (LUI), rs1 data otherwise.
//  - op2: rs2 data (OP, BRANCH), imm otherwise.
//  Control
//  - RF_WE = OPIMM|OP|JAL|JALR|LOAD|LUI|AUIPC.
//  - An unknown opcode sets ILLEGAL, clears all other ctrl bits and passes with out_valid=1.
//  HALT: if accept & in_inst==HALT_INST & RF_RD1==HALT_RD1, the next edge sets HALT=1 (sticky until reset) and loads a bubble (out_valid=0).
//  Simultaneous events: flush beats stall beats accept; out_ready with no accept drains to empty.
// TESTING
//  1 Reset, then addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, out_op1=0, out_op2=5, out_ctrl[9]=1, out_rd=1.
//  2 lw x2,0(x1) in EX (ex_is_load=1, ex_rd=2), offered add x3,x2,x1 -> in_ready=0 for 1 cycle and out_valid=0 bubble; accepted once ex_valid drops.
//  3 out_ready=0 for 3 cycles with a valid bundle -> bundle stays bit-identical and in_ready=0; release -> next instruction accepted.
//  4 flush asserted alongside in_valid -> next cycle out_valid=0, nothing captured; the following cycle accepts normally.
//  5 in_inst=0x00008067 with RF_RD1=0xc -> HALT=1 next cycle and stays 1, in_ready=0; with RF_RD1=0x10 it decodes as a normal JALR.
//  6 beq with inst[31]=1 (0xFE000EE3) -> out_imm=0xFFFFFFFC; lui 0x80000 (0x800000B7) -> out_imm=out_op2=0x80000000.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Bundle between IF, the ID stage and EX: IF offer, EX hazard info, register-file
// read port and the registered ID/EX bundle.
interface id_stage_pipe_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            ex_valid;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic [4:0]      RF_RA1;
  logic [4:0]      RF_RA2;
  logic [31:0]     RF_RD1;
  logic [31:0]     RF_RD2;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [31:0]     out_op1;
  logic [31:0]     out_op2;
  logic [31:0]     out_rs2_data;
  logic [31:0]     out_imm;
  logic [10:0]     out_ctrl;
  logic            HALT;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, ex_valid, ex_is_load, ex_rd,
           RF_RD1, RF_RD2, out_ready,
    output in_ready, RF_RA1, RF_RA2, out_valid, out_pc, out_rd, out_funct3,
           out_funct7, out_op1, out_op2, out_rs2_data, out_imm, out_ctrl, HALT
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, ex_valid, ex_is_load, ex_rd,
           RF_RD1, RF_RD2, out_ready,
    input  in_ready, RF_RA1, RF_RA2, out_valid, out_pc, out_rd, out_funct3,
           out_funct7, out_op1, out_op2, out_rs2_data, out_imm, out_ctrl, HALT
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: decodes, reads the register file, builds ALU
// operands, and handles valid/ready, load-use stalls, flush and sticky halt.
module id_stage_pipe #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] HALT_INST = 32'h00008067,
  parameter logic [31:0] HALT_RD1  = 32'h0000000c,
  parameter bit          LU_STALL  = 1'b1
) (
  input logic           CLK,
  input logic           RSTn,
  id_stage_pipe_if.slave bus
);
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic [31:0] imm_i(input logic [31:0] x);
    return {{20{x[31]}}, x[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] x);
    return {{20{x[31]}}, x[31:25], x[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] x);
    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] x);
    return {x[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] x);
    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
  endfunction

  logic [31:0]     inst;
  logic [4:0]      rs1, rs2;
  logic [10:0]     ctrl_d, ctrl_q;
  logic [31:0]     imm_d, imm_q;
  logic [31:0]     rs1_val, rs2_val;
  logic [31:0]     op1_d, op1_q, op2_d, op2_q, rs2d_q;
  logic [4:0]      rd_d, rd_q;
  logic [PC_W-1:0] pc_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic            valid_d, valid_q, halt_d, halt_q;
  logic            use1, use2, stall, accept, halt_hit, load;

  assign inst = bus.in_inst;
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign bus.RF_RA1 = rs1;
  assign bus.RF_RA2 = rs2;

  always_comb begin
    ctrl_d = '0;
    imm_d  = '0;
    case (inst[6:0])
      OPC_OPIMM:  begin ctrl_d[0] = 1'b1; imm_d = imm_i(inst); end
      OPC_OP:     ctrl_d[1] = 1'b1;
      OPC_JAL:    begin ctrl_d[2] = 1'b1; imm_d = imm_j(inst); end
      OPC_JALR:   begin ctrl_d[3] = 1'b1; imm_d = imm_i(inst); end
      OPC_BRANCH: begin ctrl_d[4] = 1'b1; imm_d = imm_b(inst); end
      OPC_LOAD:   begin ctrl_d[5] = 1'b1; imm_d = imm_i(inst); end
      OPC_STORE:  begin ctrl_d[6] = 1'b1; imm_d = imm_s(inst); end
      OPC_LUI:    begin ctrl_d[7] = 1'b1; imm_d = imm_u(inst); end
      OPC_AUIPC:  begin ctrl_d[8] = 1'b1; imm_d = imm_u(inst); end
      default:    ctrl_d[10] = 1'b1;
    endcase
    ctrl_d[9] = ctrl_d[0] | ctrl_d[1] | ctrl_d[2] | ctrl_d[3] |
                ctrl_d[5] | ctrl_d[7] | ctrl_d[8];
  end

  // x0 always reads as zero whatever the register file returns
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : bus.RF_RD1;
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : bus.RF_RD2;
  assign op1_d   = (ctrl_d[8] | ctrl_d[2]) ? 32'(bus.in_pc) :
                   ctrl_d[7]               ? 32'd0 : rs1_val;
  assign op2_d   = (ctrl_d[1] | ctrl_d[4]) ? rs2_val : imm_d;
  assign rd_d    = ctrl_d[9] ? inst[11:7] : 5'd0;

  assign use1  = !(ctrl_d[7] | ctrl_d[8] | ctrl_d[2]);
  assign use2  = ctrl_d[1] | ctrl_d[4] | ctrl_d[6];
  assign stall = LU_STALL && bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                 ((use1 && bus.ex_rd == rs1) || (use2 && bus.ex_rd == rs2));

  assign bus.in_ready = RSTn & !halt_q & !bus.flush & !stall & (!valid_q | bus.out_ready);
  assign accept   = bus.in_valid & bus.in_ready;
  assign halt_hit = (inst == HALT_INST) && (bus.RF_RD1 == HALT_RD1);

  // Flush kills everything; a halting instruction becomes a bubble
  always_comb begin
    valid_d = valid_q;
    halt_d  = halt_q;
    load    = 1'b0;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      if (halt_hit) begin
        halt_d  = 1'b1;
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        load    = 1'b1;
      end
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q  <= 1'b0;
      halt_q   <= 1'b0;
      pc_q     <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rs2d_q   <= '0;
      imm_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q <= valid_d;
      halt_q  <= halt_d;
      if (load) begin
        pc_q     <= bus.in_pc;
        rd_q     <= rd_d;
        funct3_q <= inst[14:12];
        funct7_q <= inst[31:25];
        op1_q    <= op1_d;
        op2_q    <= op2_d;
        rs2d_q   <= rs2_val;
        imm_q    <= imm_d;
        ctrl_q   <= ctrl_d;
      end
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_funct3   = funct3_q;
  assign bus.out_funct7   = funct7_q;
  assign bus.out_op1      = op1_q;
  assign bus.out_op2      = op2_q;
  assign bus.out_rs2_data = rs2d_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_ctrl     = ctrl_q;
  assign bus.HALT         = halt_q;
endmodule
